edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of event channels (2..16).
REQ-002 SHALL have parameter IDW, default 2, evt_id width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port A  input  WIDTH  asynchronous level inputs, one per channel.
REQ-006 SHALL have port cfg_mode  input  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both.
REQ-007 SHALL have port ovf_clr  input  WIDTH  one-cycle pulses clearing ovf bits.
REQ-008 SHALL have port evt_valid  output  1  event offered to consumer.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts offered event.
REQ-010 SHALL have port evt_id  output  IDW  channel index of offered event.
REQ-011 SHALL have port pend  output  WIDTH  per-channel pending flags, registered.
REQ-012 SHALL have port ovf  output  WIDTH  sticky per-channel overflow flags.

Function
REQ-013 SHALL pass each A bit through a 2-flop synchronizer (s1, s2), then a history flop s3; all reset to 0.
REQ-014 SHALL detect rise = s2 & ~s3, fall = ~s2 & s3, gated per channel by cfg_mode; detect is combinational from flops.
REQ-015 SHALL report a rising edge after reset if A is high at rstn release (history resets to 0).
REQ-016 SHALL set pend[i] on the clock edge following detection of an enabled edge on channel i.
REQ-017 SHALL set ovf[i] when an enabled edge is detected while pend[i] is already 1 and pend[i] is not being cleared that cycle; events are not queued beyond one per channel.
REQ-018 SHALL clear ovf[i] on ovf_clr[i]; a simultaneous set wins over clear.
REQ-019 SHALL clear pend[i] and ovf[i] when cfg_mode for channel i is 00, except pend[i] of the channel currently offered, which remains until accepted.
REQ-020 SHALL implement FSM with states IDLE and OFFER; reset state IDLE.
REQ-021 In IDLE, if any pend bit is set, SHALL select the first pending channel searching upward from (last_grant+1) mod WIDTH with wrap-around, register it on evt_id, and enter OFFER.
REQ-022 In OFFER, SHALL drive evt_valid=1 with evt_id stable; evt_valid SHALL NOT drop before evt_valid & evt_ready.
REQ-023 On evt_valid & evt_ready, SHALL clear pend[evt_id], set last_grant=evt_id, return to IDLE; maximum throughput one event per 2 cycles.
REQ-024 If a new enabled edge on evt_id arrives in the accept cycle, SHALL keep pend[evt_id] set, without setting ovf.
REQ-025 SHALL ignore evt_ready in IDLE.
REQ-026 Latency: A stable high before rising edge E0 (rising mode, idle arbiter) SHALL give evt_valid=1 after edge E3.
REQ-027 last_grant SHALL reset to WIDTH-1, so channel 0 has first priority after reset.
REQ-028 Pulses on A shorter than one clk period are not guaranteed to be detected.

Reset
REQ-029 While rstn=0: evt_valid=0, evt_id=0, pend=0, ovf=0, synchronizer and history flops 0, FSM IDLE, last_grant=WIDTH-1.
REQ-030 Reset assertion mid-OFFER SHALL drop evt_valid immediately (asynchronously) and discard all pending events.
REQ-031 Release of rstn SHALL be synchronized externally; block requires no extra deassertion cycles.

Verification
REQ-032 Latency: WIDTH=4, cfg_mode=01 all, evt_ready=1, A[2] 0->1 before E0 -> evt_valid=1, evt_id=2 after E3; pend[2]=0 after E4.
REQ-033 Round-robin: A[0],A[1],A[3] rise same cycle, evt_ready=1 -> ids 0,1,3 granted in order, two cycles apart; then A[0],A[3] rise -> order 3 then 0 after last_grant 3? no: order 0 then 3 (search starts at 0).
REQ-034 Backpressure/overflow: evt_ready=0, A[1] toggles 0->1->0 with mode 11 -> evt_valid held, evt_id=1 stable, ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0.
REQ-035 Mode: cfg_mode ch0=10, A[0] rises -> no event; A[0] falls -> event id 0; set ch0=00 while pend[0]=1 and not offered -> pend[0]=0 next cycle.
REQ-036 Reset: assert rstn low during OFFER -> evt_valid=0, pend=0, ovf=0 immediately; A[0] held high across release -> event id 0 reported after E3 post-release.
REQ-037 Accept collision: in accept cycle of id 2 an edge on channel 2 is detected -> pend[2] stays 1, ovf[2]=0, id 2 offered again.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: synchronizes asynchronous level inputs and detects configurable edges.
// It keeps one pending event per channel and offers events round-robin over a valid/ready handshake.
module edge_event_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     A,
    input  logic [2*WIDTH-1:0]   cfg_mode,
    input  logic [WIDTH-1:0]     ovf_clr,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDW-1:0]       evt_id,
    output logic [WIDTH-1:0]     pend,
    output logic [WIDTH-1:0]     ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] s1_reg, s2_reg, s3_reg;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic [WIDTH-1:0] ovf_reg, ovf_next;
    logic [WIDTH-1:0] chan_en;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] acc_clr;
    logic [WIDTH-1:0] offered;
    logic [WIDTH-1:0] cand;

    logic [IDW-1:0]   id_reg, id_next;
    logic [IDW-1:0]   last_reg, last_next;
    logic [IDW-1:0]   pick;
    logic             pick_found;
    logic             accept;

    assign accept = (state_reg == OFFER) && evt_ready;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [1:0] mode;
            assign mode         = cfg_mode[2*gi+1:2*gi];
            assign chan_en[gi]  = |mode;
            assign edge_det[gi] = (mode[0] &  s2_reg[gi] & ~s3_reg[gi]) |
                                  (mode[1] & ~s2_reg[gi] &  s3_reg[gi]);
            assign offered[gi]  = (state_reg == OFFER) && (id_reg == IDW'(gi));
            assign acc_clr[gi]  = offered[gi] && evt_ready;

            // A disabled channel drops its state, but an event already on offer survives until taken.
            assign pend_next[gi] = chan_en[gi] ?
                                   (edge_det[gi] | (pend_reg[gi] & ~acc_clr[gi])) :
                                   (offered[gi] & pend_reg[gi] & ~acc_clr[gi]);

            // An edge landing on a pending slot that is not being consumed is lost; set beats clear.
            assign ovf_next[gi] = chan_en[gi] &
                                  ((edge_det[gi] & pend_reg[gi] & ~acc_clr[gi]) |
                                   (ovf_reg[gi] & ~ovf_clr[gi]));
        end
    endgenerate

    assign cand = pend_reg & chan_en;

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            int idx;
            idx = (int'(last_reg) + 1 + k) % WIDTH;
            if (!pick_found && cand[idx]) begin
                pick_found = 1'b1;
                pick       = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    id_next    = pick;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    last_next  = id_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_reg    <= '0;
            s2_reg    <= '0;
            s3_reg    <= '0;
            pend_reg  <= '0;
            ovf_reg   <= '0;
            state_reg <= IDLE;
            id_reg    <= '0;
            last_reg  <= IDW'(WIDTH - 1);
        end else begin
            s1_reg    <= A;
            s2_reg    <= s1_reg;
            s3_reg    <= s2_reg;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            state_reg <= state_next;
            id_reg    <= id_next;
            last_reg  <= last_next;
        end
    end

    assign evt_valid = (state_reg == OFFER);
    assign evt_id    = id_reg;
    assign pend      = pend_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench for edge_event_arbiter against a channel-level reference model,
// plus directed latency and asynchronous-reset scenarios.
module tb_edge_event_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rstn;
    logic [W-1:0] A;
    logic [2*W-1:0] cfg_mode;
    logic [W-1:0] ovf_clr;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic [W-1:0] pend;
    logic [W-1:0] ovf;

    int n_tests;
    int n_fail;

    edge_event_arbiter #(.WIDTH(W), .IDW(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .A         (A),
        .cfg_mode  (cfg_mode),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pend      (pend),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: A as seen at previous clock edges, plus per-channel event state.
    logic [W-1:0] a_hist[$];
    bit           m_pend[W];
    bit           m_ovf[W];
    bit           m_offer;
    int           m_id;
    int           m_last;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        a_hist = '{W'(0), W'(0), W'(0)};
        for (int i = 0; i < W; i++) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
        m_offer = 1'b0;
        m_id    = 0;
        m_last  = W - 1;
    endtask

    // One clock edge of the specified behaviour, using values seen just before the edge.
    task automatic model_step();
        bit new_pend[W];
        bit new_ovf[W];
        logic [1:0] md;
        bit det, acc, was_high, is_high;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < W; i++) begin
            md       = cfg_mode[2*i +: 2];
            was_high = a_hist[2][i];
            is_high  = a_hist[1][i];
            det = (md[0] && is_high && !was_high) || (md[1] && !is_high && was_high);
            acc = m_offer && evt_ready && (m_id == i);
            if (md == 2'b00) begin
                new_ovf[i]  = 1'b0;
                new_pend[i] = (m_offer && m_id == i) ? (m_pend[i] && !acc) : 1'b0;
            end else begin
                new_pend[i] = det || (m_pend[i] && !acc);
                if (det && m_pend[i] && !acc)
                    new_ovf[i] = 1'b1;
                else if (ovf_clr[i])
                    new_ovf[i] = 1'b0;
                else
                    new_ovf[i] = m_ovf[i];
            end
        end
        if (m_offer) begin
            if (evt_ready) begin
                m_offer = 1'b0;
                m_last  = m_id;
            end
        end else begin
            for (int k = 1; k <= W; k++) begin
                int j;
                j = (m_last + k) % W;
                if (m_pend[j] && cfg_mode[2*j +: 2] != 2'b00) begin
                    m_offer = 1'b1;
                    m_id    = j;
                    break;
                end
            end
        end
        for (int i = 0; i < W; i++) begin
            m_pend[i] = new_pend[i];
            m_ovf[i]  = new_ovf[i];
        end
        a_hist.push_front(A);
        void'(a_hist.pop_back());
    endtask

    function automatic logic [W-1:0] pack(input bit v[W]);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("valid", 32'(evt_valid), 32'(m_offer));
        check_val("id",    32'(evt_id),    32'(m_id));
        check_val("pend",  32'(pend),      32'(pack(m_pend)));
        check_val("ovf",   32'(ovf),       32'(pack(m_ovf)));
        $display("[TB] t=%0t A=%b mode=%h rdy=%b valid=%b id=%0d pend=%b ovf=%b",
                 $time, A, cfg_mode, evt_ready, evt_valid, evt_id, pend, ovf);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        A         = '0;
        cfg_mode  = '0;
        ovf_clr   = '0;
        evt_ready = 1'b0;
        model_reset();
        tick();
        tick();

        // Latency: A[2] rises before E0, event offered after E3, consumed by E4.
        @(negedge clk);
        rstn      = 1'b1;
        cfg_mode  = 8'h55;
        evt_ready = 1'b1;
        A         = 4'b0100;
        tick();
        tick();
        tick();
        check_val("lat_e2_valid", 32'(evt_valid), 32'd0);
        tick();
        check_val("lat_e3_valid", 32'(evt_valid), 32'd1);
        check_val("lat_e3_id",    32'(evt_id),    32'd2);
        tick();
        check_val("lat_e4_pend2", 32'(pend[2]),  32'd0);

        // Random traffic: first with a willing consumer, then with heavy backpressure.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1200; c++) begin
                @(negedge clk);
                if ($urandom_range(3) == 0) A = A ^ W'($urandom_range(15));
                if ($urandom_range(31) == 0) cfg_mode = 8'($urandom);
                evt_ready = (phase == 0) ? 1'($urandom_range(1))
                                         : ($urandom_range(3) == 0);
                ovf_clr   = ($urandom_range(7) == 0) ? W'($urandom_range(15)) : '0;
                tick();
            end
        end

        // Drive toggling edges with no consumer until something is on offer.
        begin
            bit got_offer;
            got_offer = m_offer;
            for (int c = 0; c < 20 && !got_offer; c++) begin
                @(negedge clk);
                cfg_mode  = 8'hFF;
                evt_ready = 1'b0;
                ovf_clr   = '0;
                A         = ~A;
                tick();
                got_offer = m_offer;
            end
            check_val("offer_reached", 32'(got_offer), 32'd1);
        end

        // Asynchronous reset mid-offer clears outputs without waiting for a clock.
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_val("rst_valid", 32'(evt_valid), 32'd0);
        check_val("rst_id",    32'(evt_id),    32'd0);
        check_val("rst_pend",  32'(pend),      32'd0);
        check_val("rst_ovf",   32'(ovf),       32'd0);
        model_reset();
        A         = 4'b0001;
        cfg_mode  = 8'h55;
        evt_ready = 1'b1;
        tick();

        // A[0] held high across release reads as a rising edge.
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_val("post_rst_valid", 32'(evt_valid), 32'd1);
        check_val("post_rst_id",    32'(evt_id),    32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
